// File: rtl/axi_burst_mem_model_if.sv
// AXI4 bus bundle between the burst memory model (slave) and its master.
interface axi_burst_mem_model_if #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 1
);
  logic [ID_W-1:0]     awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_burst_mem_model.sv
// Behavioural AXI4 slave memory: FIXED/INCR/WRAP bursts, byte strobes, read latency
// and a post-reset calibration delay; one outstanding burst per direction.
module axi_burst_mem_model #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 27,
  parameter int ID_W      = 1,
  parameter int RD_LAT    = 2,
  parameter int CALIB_CYC = 16
) (
  input  logic                 clk_axi,
  input  logic                 rst_mig,
  output logic                 calib_done,
  axi_burst_mem_model_if.slave axi
);
  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_W - LSB);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, WRAP = 2'b10;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [ADDR_W-LSB-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  function automatic addr_t next_addr(addr_t a, logic [2:0] size, logic [7:0] len, logic [1:0] burst);
    addr_t bytes, nxt, wmask;
    bytes = addr_t'(1) << size;
    nxt   = (a & ~(bytes - addr_t'(1))) + bytes;
    wmask = bytes * (addr_t'(len) + addr_t'(1)) - addr_t'(1);
    case (burst)
      FIXED:   next_addr = a;
      WRAP:    next_addr = (a & ~wmask) | (nxt & wmask);
      default: next_addr = nxt;
    endcase
  endfunction

  function automatic logic burst_err(logic [31:0] a, logic [2:0] size, logic [7:0] len, logic [1:0] burst);
    logic [31:0] bmask;
    bmask = (32'd1 << size) - 32'd1;
    burst_err = (int'(size) > LSB) ||
                (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                (burst == WRAP && (a & bmask) != 32'd0);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]     cal_cnt_q, cal_cnt_d;
  logic            calib_done_q, calib_done_d;
  w_state_t        w_state_q, w_state_d;
  addr_t           waddr_q, waddr_d;
  logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]      wsize_q, wsize_d;
  logic [1:0]      wburst_q, wburst_d, bresp_q, bresp_d;
  logic [ID_W-1:0] wid_q, wid_d;
  logic            werr_q, werr_d;
  r_state_t        r_state_q, r_state_d;
  addr_t           raddr_q, raddr_d, rd_addr;
  logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]      rsize_q, rsize_d;
  logic [1:0]      rburst_q, rburst_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic            rerr_q, rerr_d, rlast_q, rlast_d, rd_load;
  logic [LAT_W-1:0] rlat_q, rlat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic            w_fire;
  idx_t            widx;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{axi.awaddr[31:ADDR_W], axi.araddr[31:ADDR_W]};

  always_comb begin
    cal_cnt_d    = cal_cnt_q;
    calib_done_d = calib_done_q;
    if (!calib_done_q) begin
      cal_cnt_d    = cal_cnt_q + 32'd1;
      calib_done_d = (cal_cnt_d >= 32'(CALIB_CYC));
    end
  end

  // Write channel: address latch, beat stepping, response
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wid_d     = wid_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (axi.awvalid && calib_done_q) begin
        waddr_d   = addr_t'(axi.awaddr);
        wlen_d    = axi.awlen;
        wsize_d   = axi.awsize;
        wburst_d  = axi.awburst;
        wid_d     = axi.awid;
        wcnt_d    = 8'd0;
        werr_d    = burst_err(axi.awaddr, axi.awsize, axi.awlen, axi.awburst);
        bresp_d   = werr_d ? SLVERR : OKAY;
        w_state_d = W_DATA;
      end
      W_DATA: if (axi.wvalid) begin
        waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
        wcnt_d  = wcnt_q + 8'd1;
        // A misplaced wlast only taints the response; the beat count still ends the burst.
        if (axi.wlast != (wcnt_q == wlen_q)) bresp_d = SLVERR;
        if (wcnt_q == wlen_q) w_state_d = W_RESP;
      end
      W_RESP: if (axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign w_fire      = (w_state_q == W_DATA) && axi.wvalid && !werr_q;
  assign widx        = waddr_q[ADDR_W-1:LSB];
  assign axi.awready = (w_state_q == W_IDLE) && calib_done_q;
  assign axi.wready  = (w_state_q == W_DATA);
  assign axi.bvalid  = (w_state_q == W_RESP);
  assign axi.bid     = wid_q;
  assign axi.bresp   = bresp_q;

  // Read channel: latency wait, then one beat per cycle with a registered data word
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rid_d     = rid_q;
    rerr_d    = rerr_q;
    rlast_d   = rlast_q;
    rlat_d    = rlat_q;
    rdata_d   = rdata_q;
    rd_addr   = raddr_q;
    rd_load   = 1'b0;
    case (r_state_q)
      R_IDLE: if (axi.arvalid && calib_done_q) begin
        raddr_d  = addr_t'(axi.araddr);
        rlen_d   = axi.arlen;
        rsize_d  = axi.arsize;
        rburst_d = axi.arburst;
        rid_d    = axi.arid;
        rcnt_d   = 8'd0;
        rlat_d   = '0;
        rerr_d   = burst_err(axi.araddr, axi.arsize, axi.arlen, axi.arburst);
        if (RD_LAT == 0) begin
          r_state_d = R_DATA;
          rd_addr   = addr_t'(axi.araddr);
          rd_load   = 1'b1;
          rlast_d   = (axi.arlen == 8'd0);
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rlat_d = rlat_q + LAT_W'(1);
        if (rlat_q == LAT_W'(RD_LAT - 1)) begin
          r_state_d = R_DATA;
          rd_load   = 1'b1;
          rlast_d   = (rlen_q == 8'd0);
        end
      end
      R_DATA: if (axi.rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rlast_d   = 1'b0;
        end else begin
          raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
          rd_addr = raddr_d;
          rcnt_d  = rcnt_q + 8'd1;
          rd_load = 1'b1;
          rlast_d = (rcnt_d == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Forward a W beat committing on the same edge so the new word sees it.
    if (rd_load) begin
      rdata_d = mem[rd_addr[ADDR_W-1:LSB]];
      if (w_fire && widx == rd_addr[ADDR_W-1:LSB]) begin
        for (int i = 0; i < NB; i++) begin
          if (axi.wstrb[i]) rdata_d[8*i +: 8] = axi.wdata[8*i +: 8];
        end
      end
      if (rerr_d) rdata_d = '0;
    end
  end

  assign axi.arready = (r_state_q == R_IDLE) && calib_done_q;
  assign axi.rvalid  = (r_state_q == R_DATA);
  assign axi.rdata   = rdata_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rerr_q ? SLVERR : OKAY;
  assign calib_done  = calib_done_q;

  always_ff @(posedge clk_axi or posedge rst_mig) begin
    if (rst_mig) begin
      cal_cnt_q    <= '0;
      calib_done_q <= 1'b0;
      w_state_q    <= W_IDLE;
      waddr_q      <= '0;
      wlen_q       <= '0;
      wcnt_q       <= '0;
      wsize_q      <= '0;
      wburst_q     <= '0;
      wid_q        <= '0;
      werr_q       <= 1'b0;
      bresp_q      <= OKAY;
      r_state_q    <= R_IDLE;
      raddr_q      <= '0;
      rlen_q       <= '0;
      rcnt_q       <= '0;
      rsize_q      <= '0;
      rburst_q     <= '0;
      rid_q        <= '0;
      rerr_q       <= 1'b0;
      rlast_q      <= 1'b0;
      rlat_q       <= '0;
      rdata_q      <= '0;
    end else begin
      cal_cnt_q    <= cal_cnt_d;
      calib_done_q <= calib_done_d;
      w_state_q    <= w_state_d;
      waddr_q      <= waddr_d;
      wlen_q       <= wlen_d;
      wcnt_q       <= wcnt_d;
      wsize_q      <= wsize_d;
      wburst_q     <= wburst_d;
      wid_q        <= wid_d;
      werr_q       <= werr_d;
      bresp_q      <= bresp_d;
      r_state_q    <= r_state_d;
      raddr_q      <= raddr_d;
      rlen_q       <= rlen_d;
      rcnt_q       <= rcnt_d;
      rsize_q      <= rsize_d;
      rburst_q     <= rburst_d;
      rid_q        <= rid_d;
      rerr_q       <= rerr_d;
      rlast_q      <= rlast_d;
      rlat_q       <= rlat_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge clk_axi) begin
    if (w_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (axi.wstrb[i]) mem[widx][8*i +: 8] <= axi.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_mem_model.sv
// Bench for axi_burst_mem_model: directed and randomized bursts against a byte-array memory model.
module tb_axi_burst_mem_model;
  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int AW = 12;
  localparam int MS = 1 << AW;
  localparam int IW = 2;
  localparam int RL = 2;
  localparam int CC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib_done;
  always #5 clk = ~clk;

  axi_burst_mem_model_if #(.DATA_W(DW), .ID_W(IW)) axi ();

  axi_burst_mem_model #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .RD_LAT(RL), .CALIB_CYC(CC)) dut (
    .clk_axi(clk), .rst_mig(rst), .calib_done(calib_done), .axi(axi)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]    ref_mem [MS];
  logic [DW-1:0] wd [256];
  logic [NB-1:0] ws [256];
  logic [DW-1:0] ex [256];

  // ---------------- reference model ----------------
  function automatic int beat_addr(int start, int len, int size, int burst, int i);
    int bytes, al, wsz, base, a;
    bytes = 1 << size;
    al = start - (start % bytes);
    if (burst == 0) a = start;
    else if (burst == 1) a = (i == 0) ? start : al + i * bytes;
    else begin
      wsz = bytes * (len + 1);
      base = start - (start % wsz);
      a = base + ((start - base + i * bytes) % wsz);
    end
    return a % MS;
  endfunction

  function automatic bit spec_err(int addr, int len, int size, int burst);
    return (size > 4) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
           (burst == 2 && (addr % (1 << size)) != 0);
  endfunction

  function automatic void model_beat(int addr, logic [DW-1:0] d, logic [NB-1:0] s);
    int w;
    w = addr / NB;
    for (int l = 0; l < NB; l++) if (s[l]) ref_mem[w * NB + l] = d[8*l +: 8];
  endfunction

  function automatic logic [DW-1:0] word_at(int addr);
    logic [DW-1:0] v;
    int w;
    w = addr / NB;
    for (int l = 0; l < NB; l++) v[8*l +: 8] = ref_mem[w * NB + l];
    return v;
  endfunction

  function automatic void model_write(int addr, int len, int size, int burst);
    for (int i = 0; i <= len; i++) model_beat(beat_addr(addr, len, size, burst, i), wd[i], ws[i]);
  endfunction

  function automatic void model_exp(int addr, int len, int size, int burst);
    for (int i = 0; i <= len; i++)
      ex[i] = spec_err(addr, len, size, burst) ? '0 : word_at(beat_addr(addr, len, size, burst, i));
  endfunction

  // ---------------- bus tasks ----------------
  task automatic send_aw(input logic [IW-1:0] id, input int addr, input int len, input int size, input int burst);
    int n;
    @(negedge clk);
    axi.awid = id; axi.awaddr = 32'(addr); axi.awlen = 8'(len);
    axi.awsize = 3'(size); axi.awburst = 2'(burst); axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (axi.awready !== 1'b1) begin n_fail++; $display("FAIL aw_accept got awready=%b exp 1", axi.awready); end
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input int len, input int bad_last);
    int n;
    for (int i = 0; i <= len; i++) begin
      axi.wdata = wd[i]; axi.wstrb = ws[i];
      axi.wlast = (bad_last != 0) ? 1'b0 : (i == len);
      axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 200) begin @(negedge clk); n++; end
      if (axi.wready !== 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL w_accept beat %0d got wready=%b exp 1", i, axi.wready);
        break;
      end
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic get_b(input logic [IW-1:0] id, input logic [1:0] er, input int hold, input string tag);
    int n;
    n = 0;
    while (!axi.bvalid && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (axi.bvalid !== 1'b1 || axi.bid !== id || axi.bresp !== er) begin
      n_fail++;
      $display("FAIL %s_b got v=%b id=%h resp=%b exp v=1 id=%h resp=%b", tag, axi.bvalid, axi.bid, axi.bresp, id, er);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_tests++;
      if (axi.bvalid !== 1'b1 || axi.bresp !== er || axi.bid !== id) begin
        n_fail++;
        $display("FAIL %s_bhold got v=%b resp=%b exp v=1 resp=%b", tag, axi.bvalid, axi.bresp, er);
      end
    end
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    n_tests++;
    if (axi.bvalid !== 1'b0) begin n_fail++; $display("FAIL %s_bdone got bvalid=%b exp 0", tag, axi.bvalid); end
  endtask

  task automatic write_burst(input logic [IW-1:0] id, input int addr, input int len, input int size,
                             input int burst, input int hold_b, input int bad_last, input string tag);
    bit err;
    err = spec_err(addr, len, size, burst);
    send_aw(id, addr, len, size, burst);
    send_w(len, bad_last);
    get_b(id, (err || bad_last != 0) ? 2'b10 : 2'b00, hold_b, tag);
    if (!err) model_write(addr, len, size, burst);
  endtask

  task automatic read_check(input logic [IW-1:0] id, input int addr, input int len, input int size,
                            input int burst, input int stall_beat, input int stall_cyc, input string tag);
    int n, lat, beat, stall, guard, bubbles;
    logic [1:0] er;
    er = spec_err(addr, len, size, burst) ? 2'b10 : 2'b00;
    @(negedge clk);
    axi.arid = id; axi.araddr = 32'(addr); axi.arlen = 8'(len);
    axi.arsize = 3'(size); axi.arburst = 2'(burst); axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 200) begin @(negedge clk); n++; end
    if (axi.arready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s_ar got arready=%b exp 1", tag, axi.arready);
      axi.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    lat = 1;
    while (!axi.rvalid && lat < 200) begin @(negedge clk); lat++; end
    n_tests++;
    if (lat != RL + 1) begin n_fail++; $display("FAIL %s_latency got %0d exp %0d", tag, lat, RL + 1); end
    beat = 0; stall = stall_cyc; guard = 0; bubbles = 0;
    while (beat <= len && guard < 2000) begin
      guard++;
      if (axi.rvalid) begin
        n_tests++;
        if (axi.rdata !== ex[beat] || axi.rlast !== (beat == len) || axi.rid !== id || axi.rresp !== er) begin
          n_fail++;
          $display("FAIL %s_beat%0d got d=%h last=%b id=%h resp=%b exp d=%h last=%b id=%h resp=%b", tag, beat,
                   axi.rdata, axi.rlast, axi.rid, axi.rresp, ex[beat], (beat == len), id, er);
        end
        if (beat == stall_beat && stall > 0) begin axi.rready = 1'b0; stall--; end
        else begin axi.rready = 1'b1; beat++; end
      end else begin
        bubbles++;
        axi.rready = 1'b1;
      end
      @(negedge clk);
    end
    axi.rready = 1'b0;
    n_tests++;
    if (beat != len + 1 || bubbles != 0 || axi.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rend got beats=%0d bubbles=%0d rvalid=%b exp beats=%0d bubbles=0 rvalid=0",
               tag, beat, bubbles, axi.rvalid, len + 1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({calib_done, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} !== 7'b0 ||
        axi.bresp !== 2'b0 || axi.rresp !== 2'b0 || axi.rdata !== '0 || axi.bid !== '0 || axi.rid !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got cal=%b aw=%b w=%b b=%b ar=%b r=%b last=%b exp all 0",
               calib_done, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast);
    end
    rst = 1'b0;
    for (int k = 1; k <= CC + 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (calib_done !== (k >= CC) || axi.awready !== (k >= CC) || axi.arready !== (k >= CC)) begin
        n_fail++;
        $display("FAIL calib_cycle%0d got cal=%b aw=%b ar=%b exp %b", k, calib_done, axi.awready, axi.arready, (k >= CC));
      end
    end
  endtask

  task automatic test_prefill();
    for (int i = 0; i < 256; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ws[i] = '1;
    end
    write_burst(2'd0, 0, 255, 4, 1, 0, 0, "prefill");
    model_exp(0, 255, 4, 1);
    read_check(2'd0, 0, 255, 4, 1, 0, 0, "prefill_rd");
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(32'hA0 + i); ws[i] = '1; end
    write_burst(2'd1, 'h100, 3, 4, 1, 0, 0, "incr");
    for (int i = 0; i < 4; i++) ex[i] = DW'(32'hA0 + i);
    read_check(2'd1, 'h100, 3, 4, 1, 0, 0, "incr_rd");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(32'hB0 + i); ws[i] = '1; end
    write_burst(2'd2, 'h120, 3, 4, 2, 0, 0, "wrap");
    for (int i = 0; i < 4; i++) ex[i] = DW'(32'hB0 + i);
    read_check(2'd2, 'h120, 3, 4, 2, 0, 0, "wrap_rd");
    ex[0] = DW'(32'hB2); ex[1] = DW'(32'hB3); ex[2] = DW'(32'hB0); ex[3] = DW'(32'hB1);
    read_check(2'd2, 'h100, 3, 4, 1, 0, 0, "wrap_layout");
  endtask

  task automatic test_narrow();
    logic [DW-1:0] expw;
    expw = word_at('h200);
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ws[i] = NB'(1) << (3 + i);
      expw[8*(3+i) +: 8] = wd[i][8*(3+i) +: 8];
    end
    write_burst(2'd3, 'h203, 3, 0, 1, 0, 0, "narrow");
    ex[0] = expw;
    read_check(2'd3, 'h200, 0, 4, 1, 0, 0, "narrow_rd");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    write_burst(2'd1, 'h600, 7, 4, 1, 3, 0, "bp");
    model_exp('h600, 7, 4, 1);
    read_check(2'd1, 'h600, 7, 4, 1, 3, 5, "bp_rd");
  endtask

  task automatic test_errors();
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    write_burst(2'd2, 'h300, 2, 4, 2, 0, 0, "err_wrap2");
    model_exp('h300, 2, 4, 1);
    read_check(2'd2, 'h300, 2, 4, 1, 0, 0, "err_unchanged");
    model_exp('h300, 2, 4, 2);
    read_check(2'd2, 'h300, 2, 4, 2, 0, 0, "err_wrap2_rd");
    model_exp('h300, 1, 5, 1);
    read_check(2'd0, 'h300, 1, 5, 1, 0, 0, "err_size");
    ws[0] = '0; ws[1] = '0;
    write_burst(2'd3, 'h340, 1, 4, 1, 0, 1, "err_wlast");
  endtask

  task automatic test_reset_mid();
    int k;
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
    send_aw(2'd1, 'h400, 3, 4, 1);
    for (int i = 0; i < 2; i++) begin
      axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = 1'b0; axi.wvalid = 1'b1;
      @(negedge clk);
    end
    axi.wdata = wd[2]; axi.wstrb = ws[2];
    rst = 1'b1;
    #1;
    n_tests++;
    if ({calib_done, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got cal=%b aw=%b w=%b b=%b ar=%b r=%b exp all 0",
               calib_done, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid);
    end
    @(negedge clk);
    axi.wvalid = 1'b0;
    rst = 1'b0;
    model_beat('h400, wd[0], ws[0]);
    model_beat('h410, wd[1], ws[1]);
    k = 0;
    while (!axi.awready && k < 100) begin @(negedge clk); k++; end
    n_tests++;
    if (k != CC) begin n_fail++; $display("FAIL midrst_calib got %0d cycles exp %0d", k, CC); end
    wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = '1;
    write_burst(2'd2, 'h500, 0, 4, 1, 0, 0, "midrst_aw");
    model_exp('h400, 3, 4, 1);
    read_check(2'd2, 'h400, 3, 4, 1, 0, 0, "midrst_rd");
  endtask

  task automatic test_random();
    int burst, size, len, addr, sb;
    int wl [4] = '{1, 3, 7, 15};
    for (int t = 0; t < 30; t++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 4);
      len   = (burst == 2) ? wl[$urandom_range(0, 3)] : $urandom_range(0, 15);
      addr  = $urandom_range(0, MS - 1);
      if (burst == 2) addr = addr - (addr % (1 << size));
      for (int i = 0; i <= len; i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom};
        ws[i] = NB'({$urandom, $urandom});
      end
      write_burst(IW'($urandom), addr, len, size, burst, $urandom_range(0, 2), 0, "rnd");
      model_exp(addr, len, size, burst);
      sb = $urandom_range(0, len);
      read_check(IW'($urandom), addr, len, size, burst, sb, $urandom_range(0, 3), "rnd_rd");
    end
  endtask

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    test_reset();
    test_prefill();
    test_incr();
    test_wrap();
    test_narrow();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
